// File: rtl/usq_pkg.sv
// rtl/usq_pkg.sv - shared types and constants for the micro sequencer, decoder and micro-ROM
package usq_pkg;

   typedef logic [4:0] uaddr_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN_IB = 2'd1,
      ST_RUN_SB = 2'd2
   } usq_state_e;

   localparam uaddr_t USQ_ILLEGAL_ADDR = 5'd31;
   localparam uaddr_t USQ_NO_SB        = 5'd0;
   localparam uaddr_t USQ_UADDR_LAST   = 5'd31;
   localparam int     USQ_MAX_STEPS    = 16;

endpackage

// File: rtl/micro_sequencer_if.sv
// rtl/micro_sequencer_if.sv - decoder/micro-ROM side bundle of the micro sequencer
interface micro_sequencer_if;
   import usq_pkg::*;

   logic       inst_valid;
   logic       inst_ready;
   uaddr_t     ib;
   uaddr_t     sb;
   logic [2:0] op_s;
   logic       uend;
   logic       hold;
   uaddr_t     upc;
   logic       uvalid;
   logic [2:0] alu_op;
   logic       phase;
   logic       done;
   logic       illegal;
   logic       fault;

   modport master (
      output inst_valid, ib, sb, op_s, uend, hold,
      input  inst_ready, upc, uvalid, alu_op, phase, done, illegal, fault
   );

   modport slave (
      input  inst_valid, ib, sb, op_s, uend, hold,
      output inst_ready, upc, uvalid, alu_op, phase, done, illegal, fault
   );

endinterface

// File: rtl/micro_sequencer.sv
// rtl/micro_sequencer.sv - steps the micro-PC through the ib routine and optional sb routine
module micro_sequencer
   import usq_pkg::*;
#(
   parameter int     MAX_STEPS    = USQ_MAX_STEPS,
   parameter uaddr_t ILLEGAL_ADDR = USQ_ILLEGAL_ADDR,
   parameter uaddr_t NO_SB        = USQ_NO_SB
) (
   input  logic               clk,
   input  logic               rst_n,
   micro_sequencer_if.slave   bus
);

   localparam int STEP_W = $clog2(MAX_STEPS + 1);

   usq_state_e        r_state;
   usq_state_e        w_next_state;
   uaddr_t            r_upc;
   uaddr_t            r_sb;
   logic [STEP_W-1:0] r_step;
   logic [2:0]        r_alu_op;
   logic              r_phase;
   logic              r_done;
   logic              r_illegal;
   logic              r_fault;

   logic w_inst_ready;
   logic w_uvalid;
   logic w_accept;
   logic w_bad;
   logic w_to_sb;
   logic w_overrun;

   assign w_accept  = bus.inst_valid && w_inst_ready;
   assign w_bad     = (bus.ib == ILLEGAL_ADDR) || (bus.sb == ILLEGAL_ADDR);
   assign w_to_sb   = (r_state == ST_RUN_IB) && (r_sb != NO_SB);
   // An unterminated word either hit the step budget or would wrap the micro-PC.
   assign w_overrun = (r_step == STEP_W'(MAX_STEPS)) || (r_upc == USQ_UADDR_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept && !w_bad) w_next_state = ST_RUN_IB;
         end
         ST_RUN_IB, ST_RUN_SB: begin
            if (w_uvalid) begin
               if (bus.uend)       w_next_state = w_to_sb ? ST_RUN_SB : ST_IDLE;
               else if (w_overrun) w_next_state = ST_IDLE;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      w_inst_ready = 1'b0;
      w_uvalid     = 1'b0;
      case (r_state)
         ST_IDLE:              w_inst_ready = rst_n;
         ST_RUN_IB, ST_RUN_SB: w_uvalid     = !bus.hold;
         default:              w_inst_ready = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_upc     <= '0;
         r_sb      <= '0;
         r_step    <= '0;
         r_alu_op  <= '0;
         r_phase   <= 1'b0;
         r_done    <= 1'b0;
         r_illegal <= 1'b0;
         r_fault   <= 1'b0;
      end else begin
         r_done    <= 1'b0;
         r_illegal <= 1'b0;
         r_fault   <= 1'b0;
         if (w_accept) begin
            r_sb     <= bus.sb;
            r_alu_op <= bus.op_s;
            if (w_bad) begin
               r_illegal <= 1'b1;
            end else begin
               r_upc   <= bus.ib;
               r_step  <= STEP_W'(1);
               r_phase <= 1'b0;
            end
         end else if (w_uvalid) begin
            if (bus.uend) begin
               if (w_to_sb) begin
                  r_upc   <= r_sb;
                  r_step  <= STEP_W'(1);
                  r_phase <= 1'b1;
               end else begin
                  r_done <= 1'b1;
               end
            end else if (w_overrun) begin
               r_fault <= 1'b1;
            end else begin
               r_upc  <= r_upc + 5'd1;
               r_step <= r_step + STEP_W'(1);
            end
         end
      end
   end

   assign bus.inst_ready = w_inst_ready;
   assign bus.uvalid     = w_uvalid;
   assign bus.upc        = r_upc;
   assign bus.alu_op     = r_alu_op;
   assign bus.phase      = r_phase;
   assign bus.done       = r_done;
   assign bus.illegal    = r_illegal;
   assign bus.fault      = r_fault;

endmodule

// File: tb/tb_micro_sequencer.sv
// tb/tb_micro_sequencer.sv - directed and randomized checks of micro_sequencer against a routine-level model
module tb_micro_sequencer;
   import usq_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   micro_sequencer_if bus();

   micro_sequencer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [4:0] addr;
      logic       ph;
      logic       last;
   } word_t;

   word_t q[$];
   int    outcome;   // 0 done, 1 illegal, 2 fault
   int    n_cmp = 0;
   int    n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   // Expand one routine into the words it issues; ok=0 means it ran away.
   task automatic add_routine(input logic [4:0] start, input int len, input logic ph, output bit ok);
      int a;
      int step;
      a    = int'(start);
      step = 1;
      ok   = 1'b0;
      forever begin
         q.push_back('{a[4:0], ph, (step == len)});
         if (step == len) begin
            ok = 1'b1;
            return;
         end
         if (step == USQ_MAX_STEPS || a == 31) return;
         a++;
         step++;
      end
   endtask

   task automatic model(input logic [4:0] ib, input logic [4:0] sb, input int len_ib, input int len_sb);
      bit ok;
      q.delete();
      if (ib == 5'd31 || sb == 5'd31) begin
         outcome = 1;
         return;
      end
      add_routine(ib, len_ib, 1'b0, ok);
      if (ok && sb != 5'd0) add_routine(sb, len_sb, 1'b1, ok);
      outcome = ok ? 0 : 2;
   endtask

   // Entered and left at posedge+1; hold_mode 0 none, 1 random, 2 two cycles on the first word.
   task automatic run_inst(input logic [4:0] ib, input logic [4:0] sb, input logic [2:0] op,
                           input int len_ib, input int len_sb, input int hold_mode);
      int  idx;
      int  cyc;
      int  hcnt;
      bit  h;
      model(ib, sb, len_ib, len_sb);
      bus.inst_valid = 1'b1;
      bus.ib   = ib;
      bus.sb   = sb;
      bus.op_s = op;
      bus.hold = 1'b0;
      bus.uend = 1'b0;
      #1;
      chk("ready_at_accept", {31'd0, bus.inst_ready}, 32'd1);
      @(posedge clk);
      #1;
      bus.inst_valid = 1'b0;
      bus.ib   = 5'($urandom);
      bus.sb   = 5'($urandom);
      bus.op_s = 3'($urandom);
      idx  = 0;
      cyc  = 1;
      hcnt = 0;
      while (idx < q.size() && cyc < 200) begin
         if (hold_mode == 1)      h = ($urandom_range(3) == 0);
         else if (hold_mode == 2) h = (idx == 0 && hcnt < 2);
         else                     h = 1'b0;
         if (h) hcnt++;
         bus.hold       = h;
         bus.uend       = h ? 1'($urandom) : q[idx].last;
         bus.inst_valid = 1'($urandom);
         @(negedge clk);
         chk("uvalid",      {31'd0, bus.uvalid}, {31'd0, !h});
         chk("upc",         {27'd0, bus.upc}, {27'd0, q[idx].addr});
         chk("phase",       {31'd0, bus.phase}, {31'd0, q[idx].ph});
         chk("alu_op_run",  {29'd0, bus.alu_op}, {29'd0, op});
         chk("ready_busy",  {31'd0, bus.inst_ready}, 32'd0);
         chk("pulses_busy", {29'd0, bus.done, bus.illegal, bus.fault}, 32'd0);
         if (!h) idx++;
         @(posedge clk);
         #1;
         cyc++;
      end
      bus.hold       = 1'b0;
      bus.uend       = 1'b0;
      bus.inst_valid = 1'b0;
      chk("done",       {31'd0, bus.done},    (outcome == 0) ? 32'd1 : 32'd0);
      chk("illegal",    {31'd0, bus.illegal}, (outcome == 1) ? 32'd1 : 32'd0);
      chk("fault",      {31'd0, bus.fault},   (outcome == 2) ? 32'd1 : 32'd0);
      chk("ready_end",  {31'd0, bus.inst_ready}, 32'd1);
      chk("uvalid_end", {31'd0, bus.uvalid}, 32'd0);
      chk("alu_op_end", {29'd0, bus.alu_op}, {29'd0, op});
      chk("latency",    cyc, q.size() + hcnt + 1);
   endtask

   task automatic chk_all_zero(input string tag, input logic ready_exp);
      chk({tag, "_upc"},    {27'd0, bus.upc}, 32'd0);
      chk({tag, "_alu_op"}, {29'd0, bus.alu_op}, 32'd0);
      chk({tag, "_phase"},  {31'd0, bus.phase}, 32'd0);
      chk({tag, "_uvalid"}, {31'd0, bus.uvalid}, 32'd0);
      chk({tag, "_pulses"}, {29'd0, bus.done, bus.illegal, bus.fault}, 32'd0);
      chk({tag, "_ready"},  {31'd0, bus.inst_ready}, {31'd0, ready_exp});
   endtask

   initial begin
      bus.inst_valid = 1'b0;
      bus.ib   = '0;
      bus.sb   = '0;
      bus.op_s = '0;
      bus.uend = 1'b0;
      bus.hold = 1'b0;
      #12;
      chk_all_zero("reset", 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk_all_zero("post_reset", 1'b1);

      run_inst(5'd17, 5'd0,  3'd2, 3, 0, 0);
      run_inst(5'd5,  5'd12, 3'd3, 2, 2, 0);
      run_inst(5'd9,  5'd0,  3'd1, 1, 0, 0);
      run_inst(5'd31, 5'd31, 3'd4, 1, 1, 0);
      run_inst(5'd4,  5'd31, 3'd6, 2, 2, 0);
      run_inst(5'd1,  5'd10, 3'd5, 3, 2, 2);
      run_inst(5'd5,  5'd0,  3'd6, 99, 0, 0);
      run_inst(5'd30, 5'd0,  3'd7, 99, 0, 0);
      run_inst(5'd2,  5'd29, 3'd1, 1, 99, 0);

      bus.inst_valid = 1'b1;
      bus.ib   = 5'd3;
      bus.sb   = 5'd0;
      bus.op_s = 3'd5;
      @(posedge clk);
      #1;
      bus.inst_valid = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk_all_zero("mid_reset", 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk_all_zero("after_mid_reset", 1'b1);

      for (int i = 0; i < 40; i++) begin
         logic [4:0] rib;
         logic [4:0] rsb;
         rib = 5'($urandom_range(31));
         rsb = ($urandom_range(2) == 0) ? 5'd0 : 5'($urandom_range(31));
         run_inst(rib, rsb, 3'($urandom), int'($urandom_range(1, 20)),
                  int'($urandom_range(1, 20)), int'($urandom_range(1)));
         if ($urandom_range(1) == 1) begin
            @(posedge clk);
            #1;
            chk("idle_gap_ready", {31'd0, bus.inst_ready}, 32'd1);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/micro_sequencer.md
# micro_sequencer

Microprogram sequencer sitting directly downstream of the instruction decoder. It accepts a decoded instruction (entry micro-address `ib`, optional second-routine address `sb`, ALU operation `op_s`) over a valid/ready handshake. It then steps a 5-bit micro-program counter through the `ib` routine and, when present, the `sb` routine, driving the micro-ROM address and the ALU operation code. It signals completion, illegal instructions and runaway routines.

## Interface
Parameters:
- `MAX_STEPS`, 16: maximum micro-words per routine before a fault.
- `ILLEGAL_ADDR`, 5'd31: decoder marker for an undecodable instruction.
- `NO_SB`, 5'd0: `sb` value meaning "no second routine".

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `inst_valid`  in  1  decoded instruction present.
- `inst_ready`  out  1  sequencer can accept an instruction.
- `ib`  in  5  entry micro-address of the first routine.
- `sb`  in  5  entry micro-address of the second routine (`NO_SB` = none).
- `op_s`  in  3  ALU operation code.
- `uend`  in  1  micro-ROM flag: the word at `upc` is the last word of its routine.
- `hold`  in  1  freeze sequencing (datapath stall).
- `upc`  out  5  micro-ROM address.
- `uvalid`  out  1  the word at `upc` executes this cycle.
- `alu_op`  out  3  latched `op_s`.
- `phase`  out  1  0 = `ib` routine, 1 = `sb` routine.
- `done`  out  1  one-cycle pulse: instruction completed.
- `illegal`  out  1  one-cycle pulse: instruction rejected.
- `fault`  out  1  one-cycle pulse: routine aborted.

## Operation
- FSM states: IDLE, RUN_IB, RUN_SB.
- IDLE:
  - `inst_ready`=1, `uvalid`=0.
  - Accept occurs when `inst_valid`&`inst_ready`. On accept, latch `sb` and `op_s`→`alu_op`.
  - If `ib`==ILLEGAL_ADDR or `sb`==ILLEGAL_ADDR: stay in IDLE, `illegal`=1 next cycle, no micro-words issued.
  - Otherwise: `upc`←`ib`, step counter←1, `phase`←0, go to RUN_IB.
- RUN_IB / RUN_SB:
  - `inst_ready`=0 and `uvalid`=!`hold`.
  - While `hold`=1: all state frozen, including `upc`, the step counter and `phase`.
  - On an executing cycle with `uend`=1, in RUN_IB with latched `sb`!=NO_SB: `upc`←`sb`, `phase`←1, step counter←1, go to RUN_SB.
  - On an executing cycle with `uend`=1, otherwise: go to IDLE with `done`=1 next cycle.
  - On an executing cycle with `uend`=0: `upc`←`upc`+1 and step counter +1.
- Fault conditions (checked on executing cycles with `uend`=0):
  - step counter == MAX_STEPS, or
  - `upc`==5'd31 (increment would wrap).
  - Either one aborts to IDLE with `fault`=1 next cycle; no wrap to 0 is ever issued.
- `inst_valid` is ignored outside IDLE. `ib`/`sb`/`op_s` are sampled only at accept.
- Back-to-back: an instruction is accepted in the same cycle that `done`, `illegal` or `fault` is high, because the FSM is already in IDLE.
- `uend` is ignored when `uvalid`=0.

## Timing
- Reset (asynchronous, any state, mid-routine included):
  - state IDLE
  - `upc`=0, `alu_op`=0, `phase`=0
  - `uvalid`=0, `done`=0, `illegal`=0, `fault`=0
  - `inst_ready`=1 once `rst_n` is high.
  - A routine in flight is discarded silently.
- Accept at cycle T: `upc`=`ib` and `uvalid`=1 at T+1, with zero hold.
- One micro-word per non-held cycle. The switch from `ib` to `sb` costs no bubble cycle.
- Last word at cycle L: `done` at L+1, with `inst_ready`=1 at L+1.
- Total latency with no holds = words(`ib`) + words(`sb`) + 1 cycles, from accept to `done`.
- `illegal` occurs at T+1. `fault` occurs in the cycle after the offending word.
- All outputs are registered, except `inst_ready` and `uvalid`, which are decoded from state and `hold`.

## Structure
- Shared package `usq_pkg`:
  - state enum (IDLE, RUN_IB, RUN_SB)
  - ILLEGAL_ADDR, NO_SB, the default MAX_STEPS
  - 5-bit micro-address type
- The package is shared with the instruction decoder and the micro-ROM.
- Single module; the step counter stays inline. The micro-ROM is external.

## Test plan
- `ib`=17, `sb`=0, `op_s`=2, `uend` on the 3rd word:
  - `upc` 17,18,19 at T+1..T+3, `phase`=0
  - `alu_op`=2
  - `done` at T+4
- `ib`=5, `sb`=12, `uend` on the 2nd word of each routine:
  - `upc` 5,6,12,13
  - `phase` 0,0,1,1
  - `done` at T+5, with a new accept at T+5 honoured.
- `ib`=31, `sb`=31:
  - `illegal`=1 at T+1
  - `uvalid` never high
  - `inst_ready` stays 1
- `ib`=1, `sb`=10, `hold`=1 for 2 cycles after the first word:
  - `upc` stays 1 with `uvalid`=0 for 2 cycles, then 2
  - the sequence completes normally.
- `ib`=5, `uend` never asserted:
  - `upc` 5..20 (16 words)
  - `fault`=1 the next cycle, then IDLE.
- `ib`=30, `uend` never asserted:
  - `upc` 30,31
  - `fault` the next cycle, no 0 issued.
  - Separate case: `rst_n` low mid-routine → all outputs 0 immediately, IDLE afterwards.
